// File: rtl/fpa_seq_pkg.sv
// Shared types and constants for the FPA display sequencer: FSM state
// encoding, the built-in operand test-vector table and counter widths.
package fpa_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CAPTURE,
        S_WAIT_FRAME,
        S_COMMIT
    } seq_state_t;

    // One test vector: operand pair fed to the adder.
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
    } vec_t;

    // SETTLE_CYCLES is limited to 1..15, so 4 bits are enough.
    localparam int SETTLE_W = 4;
    localparam int IDX_W    = 3;

    // Entry 0 is the rightmost element. Entries 2..6 exercise carries,
    // a near-overflow and a saturating sum.
    localparam vec_t [7:0] VEC_TABLE = {
        16'hFFFF,   // 7
        16'h8090,   // 6
        16'h7F01,   // 5
        16'h403F,   // 4
        16'h1020,   // 3
        16'h0102,   // 2
        16'h5F21,   // 1
        16'h3030    // 0
    };

endpackage

// File: rtl/fpa_display_sequencer_if.sv
// Board/adder/VGA-side signal bundle of the FPA display sequencer.
// slave = the sequencer, master = whatever drives the board inputs and
// models the adder.
interface fpa_display_sequencer_if;
    logic       mode_sw;
    logic [7:0] sw_a;
    logic [7:0] sw_b;
    logic       next_btn;
    logic       new_frame;
    logic [7:0] fpa_result;
    logic [7:0] fpa_a;
    logic [7:0] fpa_b;
    logic [7:0] disp_a;
    logic [7:0] disp_b;
    logic [7:0] disp_result;
    logic [2:0] vec_idx;
    logic       busy;

    modport slave (
        input  mode_sw, sw_a, sw_b, next_btn, new_frame, fpa_result,
        output fpa_a, fpa_b, disp_a, disp_b, disp_result, vec_idx, busy
    );

    modport master (
        output mode_sw, sw_a, sw_b, next_btn, new_frame, fpa_result,
        input  fpa_a, fpa_b, disp_a, disp_b, disp_result, vec_idx, busy
    );
endinterface

// File: rtl/fpa_seq_vec_rom.sv
// Combinational test-vector lookup: table index -> {A, B} operand pair.
module fpa_seq_vec_rom
    import fpa_seq_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output vec_t             entry
);

    assign entry = VEC_TABLE[idx];

endmodule

// File: rtl/fpa_display_sequencer.sv
// FPA display sequencer: loads operand pairs into the adder, waits for the
// result to settle, captures it, and publishes the A/B/result triple to the
// VGA driver only at a frame boundary so the display never tears.
// Optional feature: define FPA_SEQ_AUTO_EN for a periodic auto-advance tick.
module fpa_display_sequencer
    import fpa_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int NUM_VEC       = 8,
    parameter int AUTO_PERIOD   = 25_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    fpa_display_sequencer_if.slave bus
);

    seq_state_t          state;
    logic                pending;
    logic                adv_req;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [IDX_W-1:0]    vec_idx_q;
    logic [7:0]          fpa_a_q, fpa_b_q;
    logic [7:0]          last_a, last_b;
    logic                last_mode;
    logic [7:0]          sh_a, sh_b, sh_r;
    logic [7:0]          disp_a_q, disp_b_q, disp_r_q;
    logic                busy_q;

    logic                auto_tick;
    logic                sw_diff;
    logic                adv_now;
    logic                trig;
    logic [IDX_W-1:0]    idx_adv;
    logic [IDX_W-1:0]    idx_sel;
    vec_t                rom_entry;

`ifdef FPA_SEQ_AUTO_EN
    localparam int AUTO_W = $clog2(AUTO_PERIOD + 1);
    logic [AUTO_W-1:0] auto_cnt;

    // Free-running auto-advance counter; tick on its terminal count.
    always_ff @(posedge clk) begin
        if (reset)
            auto_cnt <= '0;
        else if (auto_cnt == AUTO_W'(AUTO_PERIOD - 1))
            auto_cnt <= '0;
        else
            auto_cnt <= auto_cnt + 1'b1;
    end

    assign auto_tick = (auto_cnt == AUTO_W'(AUTO_PERIOD - 1));
`else
    // No auto-advance: the tick never fires.
    assign auto_tick = 1'b0 & (AUTO_PERIOD == 0);
`endif

    // Manual mode re-runs whenever the switches differ from what was last
    // loaded; this is a level condition, so it also covers mode changes.
    assign sw_diff = !bus.mode_sw &&
                     (bus.sw_a != last_a || bus.sw_b != last_b || bus.mode_sw != last_mode);
    // Index-advancing triggers; the auto tick only counts in vector mode.
    assign adv_now = bus.next_btn | (auto_tick & bus.mode_sw);
    assign trig    = adv_now | sw_diff;

    assign idx_adv = (vec_idx_q == IDX_W'(NUM_VEC - 1)) ? '0 : vec_idx_q + 1'b1;
    assign idx_sel = (adv_req && bus.mode_sw) ? idx_adv : vec_idx_q;

    fpa_seq_vec_rom u_rom (
        .idx   (idx_sel),
        .entry (rom_entry)
    );

    // Sequencer FSM with registered operand, shadow and display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            pending    <= 1'b1;
            adv_req    <= 1'b0;
            settle_cnt <= '0;
            vec_idx_q  <= '0;
            fpa_a_q    <= '0;
            fpa_b_q    <= '0;
            last_a     <= '0;
            last_b     <= '0;
            last_mode  <= 1'b0;
            sh_a       <= '0;
            sh_b       <= '0;
            sh_r       <= '0;
            disp_a_q   <= '0;
            disp_b_q   <= '0;
            disp_r_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            // Any trigger collapses into the one-deep request; LOAD consumes it.
            if (state != S_LOAD) begin
                pending <= pending | trig;
                adv_req <= adv_req | adv_now;
            end
            case (state)
                S_IDLE: begin
                    if (pending || trig) begin
                        state  <= S_LOAD;
                        busy_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (adv_req && bus.mode_sw)
                        vec_idx_q <= idx_adv;
                    if (bus.mode_sw) begin
                        fpa_a_q <= rom_entry.a;
                        fpa_b_q <= rom_entry.b;
                    end else begin
                        fpa_a_q <= bus.sw_a;
                        fpa_b_q <= bus.sw_b;
                    end
                    last_a     <= bus.sw_a;
                    last_b     <= bus.sw_b;
                    last_mode  <= bus.mode_sw;
                    // Switch differences seen here are against the old
                    // snapshot and are re-evaluated next cycle, so only
                    // button/tick pulses landing in LOAD are kept.
                    pending    <= adv_now;
                    adv_req    <= adv_now;
                    settle_cnt <= '0;
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1))
                        state <= S_CAPTURE;
                    else
                        settle_cnt <= settle_cnt + 1'b1;
                end
                S_CAPTURE: begin
                    sh_a  <= fpa_a_q;
                    sh_b  <= fpa_b_q;
                    sh_r  <= bus.fpa_result;
                    state <= S_WAIT_FRAME;
                end
                S_WAIT_FRAME: begin
                    if (bus.new_frame)
                        state <= S_COMMIT;
                end
                S_COMMIT: begin
                    disp_a_q <= sh_a;
                    disp_b_q <= sh_b;
                    disp_r_q <= sh_r;
                    state    <= S_IDLE;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fpa_a       = fpa_a_q;
    assign bus.fpa_b       = fpa_b_q;
    assign bus.disp_a      = disp_a_q;
    assign bus.disp_b      = disp_b_q;
    assign bus.disp_result = disp_r_q;
    assign bus.vec_idx     = vec_idx_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_fpa_display_sequencer.sv
// Scoreboard bench for fpa_display_sequencer: directed stimulus pushes the
// expected displayed triple; a monitor pops and compares on every COMMIT
// (busy falling outside reset).
module tb_fpa_display_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_en = 1'b1;

    fpa_display_sequencer_if bus ();

    fpa_display_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Adder model: saturating 8-bit add.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    assign bus.fpa_result = sat_add(bus.fpa_a, bus.fpa_b);

    int n_cmp = 0;
    int n_bad = 0;
    int commits = 0;
    logic [23:0] sb[$];

    // Hand-computed {A, B, A+B saturated} for each table entry.
    logic [23:0] exp_tab [8] = '{
        24'h303060, 24'h5F2180, 24'h010203, 24'h102030,
        24'h403F7F, 24'h7F0180, 24'h8090FF, 24'hFFFFFF
    };

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endfunction

    // Frame pulse generator: one-cycle new_frame every 100 cycles.
    initial begin
        int fc = 0;
        bus.new_frame = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            fc++;
            if (frame_en) bus.new_frame = (fc % 100 == 0);
        end
    end

    // Monitor: each busy 1->0 transition outside reset is a COMMIT.
    initial begin
        logic prev_busy = 1'b0;
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_busy = 1'b0;
            end else begin
                if (prev_busy && !bus.busy) begin
                    commits++;
                    if (sb.size() == 0) begin
                        check("unexpected_commit", {bus.disp_a, bus.disp_b, bus.disp_result}, 32'hDEAD);
                    end else begin
                        e = sb.pop_front();
                        check("disp_triple", {8'h00, bus.disp_a, bus.disp_b, bus.disp_result}, {8'h00, e});
                    end
                end
                prev_busy = bus.busy;
            end
        end
    end

    task automatic press_btn();
        @(posedge clk); #1 bus.next_btn = 1'b1;
        @(posedge clk); #1 bus.next_btn = 1'b0;
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check(nm, sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_busy();
        int t = 0;
        while (!bus.busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("busy_rise", bus.busy, 1);
    endtask

    initial begin
        int c0;
        bus.mode_sw  = 1'b1;
        bus.sw_a     = 8'h00;
        bus.sw_b     = 8'h00;
        bus.next_btn = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_fpa_a", bus.fpa_a, 0);
        check("rst_disp_a", bus.disp_a, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_vec_idx", bus.vec_idx, 0);

        // First sequence after reset: entry 0
        sb.push_back(exp_tab[0]);
        reset = 1'b0;
        wait_busy();
        @(posedge clk); @(negedge clk);
        check("load0_fpa_a", bus.fpa_a, 8'h30);
        check("load0_fpa_b", bus.fpa_b, 8'h30);
        drain("drain_first");
        check("busy_after_commit", bus.busy, 0);

        // next_btn in IDLE: entry 1, display held until frame
        sb.push_back(exp_tab[1]);
        @(posedge clk); #1 bus.next_btn = 1'b1;
        @(posedge clk); #1 bus.next_btn = 1'b0;
        @(posedge clk); @(negedge clk);
        check("btn_vec_idx", bus.vec_idx, 1);
        check("btn_fpa_a", bus.fpa_a, 8'h5F);
        check("btn_fpa_b", bus.fpa_b, 8'h21);
        check("disp_held", {bus.disp_a, bus.disp_b, bus.disp_result}, 24'h303060);
        drain("drain_btn");

        // Walk to index 7, then wrap to 0
        for (int i = 2; i <= 8; i++) begin
            sb.push_back(exp_tab[i % 8]);
            press_btn();
            drain("drain_walk");
            check("walk_vec_idx", bus.vec_idx, i % 8);
        end

        // One press plus three presses during SETTLE: exactly two sequences
        sb.push_back(exp_tab[1]);
        sb.push_back(exp_tab[2]);
        press_btn();
        repeat (3) begin
            @(posedge clk); #1 bus.next_btn = 1'b1;
            @(posedge clk); #1 bus.next_btn = 1'b0;
        end
        drain("drain_multi");
        c0 = commits;
        repeat (150) @(negedge clk);
        check("multi_no_extra", commits, c0);
        check("multi_vec_idx", bus.vec_idx, 2);

        // Manual mode: switch change runs exactly one sequence
        sb.push_back(24'h123446);
        @(posedge clk); #1;
        bus.mode_sw = 1'b0;
        bus.sw_a    = 8'h12;
        bus.sw_b    = 8'h34;
        drain("drain_manual");
        c0 = commits;
        repeat (300) @(negedge clk);
        check("manual_no_rerun", commits, c0);
        check("manual_vec_idx", bus.vec_idx, 2);

        // Reset during WAIT_FRAME
        frame_en = 1'b0;
        bus.new_frame = 1'b0;
        c0 = commits;
        @(posedge clk); #1 bus.sw_a = 8'h20;
        wait_busy();
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check("abort_fpa_a", bus.fpa_a, 0);
        check("abort_fpa_b", bus.fpa_b, 0);
        check("abort_disp", {bus.disp_a, bus.disp_b, bus.disp_result}, 0);
        check("abort_vec_idx", bus.vec_idx, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_no_commit", commits, c0);
        sb.push_back(24'h203454);
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 bus.new_frame = 1'b1;
        @(posedge clk); #1 bus.new_frame = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stray_frame_disp", bus.disp_a, 0);
        check("stray_frame_busy", bus.busy, 1);
        @(posedge clk); #1 bus.new_frame = 1'b1;
        @(posedge clk); #1 bus.new_frame = 1'b0;
        drain("drain_restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
